// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues one IM read per cycle while
// credit allows, and buffers {pc, inst, jump} for decode in a small FIFO.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] IM_addr,
  output logic        IM_en,
  input  logic [31:0] IM_rdata,
  output logic        DC_ready,
  input  logic [31:0] next_pc,
  input  logic        jump_out,
  input  logic        mispredict,
  output logic        fq_valid,
  output logic [31:0] fq_pc,
  output logic [31:0] fq_inst,
  output logic        fq_jump,
  input  logic        fq_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_O = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
  } fq_entry_t;

  fq_entry_t      mem [DEPTH];
  logic [31:0]    pc, pend_pc;
  logic           pend_jump, inflight;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;
  logic [CW:0]    occ_raw, occ;
  logic           pop, push, issue;

  // Credit counts the outstanding read so a full FIFO never receives a push;
  // a pop this cycle frees a slot early so issue resumes without a bubble.
  assign occ_raw  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign occ      = occ_raw - {{CW{1'b0}}, pop};
  assign fq_valid = rst & (count != '0) & ~mispredict;
  assign pop      = fq_valid & fq_ready;
  assign push     = inflight & ~mispredict;
  assign issue    = rst & ~mispredict & (occ < DEPTH_O);

  assign IM_addr  = pc;
  assign IM_en    = issue;
  assign DC_ready = issue;

  assign fq_pc    = mem[rd_ptr].pc;
  assign fq_inst  = mem[rd_ptr].inst;
  assign fq_jump  = mem[rd_ptr].jump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      pend_pc   <= RESET_PC;
      pend_jump <= 1'b0;
      inflight  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (mispredict) begin
      pc       <= next_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      pc       <= next_pc;
      inflight <= issue;
      if (issue) begin
        pend_pc   <= pc;
        pend_jump <= jump_out;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pend_pc, inst: IM_rdata, jump: pend_jump};
  end

  assert property (@(posedge clk) disable iff (!rst) occ_raw <= DEPTH_O);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: predictor/IM model plus a scoreboard of issued fetches
// compared at every decode pop, with directed reset/backpressure/flush cases.
module tb_fetch_queue;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] IM_addr, IM_rdata, next_pc, fq_pc, fq_inst;
  logic        IM_en, DC_ready, jump_out, mispredict, fq_valid, fq_jump, fq_ready;
  logic        redir_en;
  logic [31:0] redir_pc, im_q;
  int          nchk = 0, nfail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        jump;
  } exp_t;
  exp_t sb[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .IM_addr(IM_addr), .IM_en(IM_en), .IM_rdata(IM_rdata),
    .DC_ready(DC_ready), .next_pc(next_pc), .jump_out(jump_out),
    .mispredict(mispredict), .fq_valid(fq_valid), .fq_pc(fq_pc),
    .fq_inst(fq_inst), .fq_jump(fq_jump), .fq_ready(fq_ready)
  );

  always #5 clk = ~clk;

  // Instruction memory: word is a function of the address, returned a cycle later.
  always @(posedge clk) im_q <= IM_addr;
  assign IM_rdata = im_q ^ K;

  // Predictor: hold when not advancing, +4 otherwise, redirect when asked.
  always_comb begin
    next_pc = DC_ready ? IM_addr + 32'd4 : IM_addr;
    if (redir_en) next_pc = redir_pc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst || mispredict) sb.delete();
    else begin
      if (fq_valid && fq_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_pc", fq_pc, e.pc);
          chk("sb_inst", fq_inst, e.inst);
          chk("sb_jump", {31'd0, fq_jump}, {31'd0, e.jump});
        end
      end
      if (IM_en) sb.push_back('{IM_addr, IM_addr ^ K, jump_out});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bit done, saw, hit;
    fq_ready = 1'b1; mispredict = 1'b0; jump_out = 1'b0;
    redir_en = 1'b0; redir_pc = '0;

    // Reset then streaming
    repeat (3) tick();
    smp();
    chk("rst_en", {31'd0, IM_en}, 32'd0);
    chk("rst_vld", {31'd0, fq_valid}, 32'd0);
    chk("rst_addr", IM_addr, 32'h0);
    tick(); rst = 1'b1; smp();
    chk("c0_en", {31'd0, IM_en}, 32'd1);
    chk("c0_addr", IM_addr, 32'h0);
    tick(); smp();
    chk("c1_addr", IM_addr, 32'h4);
    chk("c1_vld", {31'd0, fq_valid}, 32'd0);
    tick(); smp();
    chk("c2_addr", IM_addr, 32'h8);
    chk("c2_vld", {31'd0, fq_valid}, 32'd1);
    chk("c2_pc", fq_pc, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick(); smp();
      chk("stream_vld", {31'd0, fq_valid}, 32'd1);
      chk("stream_pc", fq_pc, 32'(4 * (i + 1)));
    end

    // Backpressure from reset
    tick(); rst = 1'b0; fq_ready = 1'b0;
    repeat (2) tick();
    tick(); rst = 1'b1; smp();
    chk("bp_en0", {31'd0, IM_en}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick(); smp();
      chk("bp_en", {31'd0, IM_en}, 32'd1);
      chk("bp_addr", IM_addr, 32'(4 * i));
    end
    for (int i = 0; i < 4; i++) begin
      tick(); smp();
      chk("full_en", {31'd0, IM_en}, 32'd0);
      chk("full_addr", IM_addr, 32'h10);
      chk("full_pc", fq_pc, 32'h0);
    end
    tick(); fq_ready = 1'b1; smp();
    chk("pulse_en", {31'd0, IM_en}, 32'd1);
    chk("pulse_pc", fq_pc, 32'h0);
    tick(); fq_ready = 1'b0; smp();
    chk("post_pulse_en", {31'd0, IM_en}, 32'd0);
    chk("post_pulse_addr", IM_addr, 32'h14);

    // Mispredict with 8,12 queued and 16 in flight
    tick(); rst = 1'b0;
    repeat (2) tick();
    tick(); rst = 1'b1;
    tick();
    tick(); fq_ready = 1'b1;
    tick();
    tick(); fq_ready = 1'b0; smp();
    chk("mp_pre_pc", fq_pc, 32'h8);
    chk("mp_pre_addr", IM_addr, 32'h10);
    tick(); mispredict = 1'b1; redir_en = 1'b1; redir_pc = 32'h40; smp();
    chk("mp_vld", {31'd0, fq_valid}, 32'd0);
    chk("mp_en", {31'd0, IM_en}, 32'd0);
    tick(); mispredict = 1'b0; redir_en = 1'b0; fq_ready = 1'b1; smp();
    chk("mp_addr", IM_addr, 32'h40);
    chk("mp_resume_en", {31'd0, IM_en}, 32'd1);
    chk("mp_empty", {31'd0, fq_valid}, 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(); smp();
      if (fq_valid) hit = 1'b1;
    end
    if (hit) chk("mp_first_pc", fq_pc, 32'h40);
    else     chk("mp_timeout", 32'd0, 32'd1);

    // Predicted jump at 0x10 -> 0x80
    tick(); rst = 1'b0;
    repeat (2) tick();
    tick(); rst = 1'b1;
    done = 1'b0; saw = 1'b0; hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (i > 0) tick();
      jump_out = 1'b0; redir_en = 1'b0;
      if (IM_addr == 32'h10 && IM_en && !done) begin
        jump_out = 1'b1; redir_en = 1'b1; redir_pc = 32'h80; done = 1'b1;
      end
      smp();
      if (fq_valid && fq_ready) begin
        if (saw) begin
          chk("jmp_next_pc", fq_pc, 32'h80);
          chk("jmp_next_bit", {31'd0, fq_jump}, 32'd0);
          hit = 1'b1;
        end else if (fq_pc == 32'h10) begin
          chk("jmp_bit", {31'd0, fq_jump}, 32'd1);
          saw = 1'b1;
        end
      end
    end
    if (!hit) chk("jmp_timeout", 32'd0, 32'd1);

    // Async reset between edges with 3 entries queued
    tick(); jump_out = 1'b0; redir_en = 1'b0; fq_ready = 1'b0;
    tick();
    tick();
    chk("arst_pre_vld", {31'd0, fq_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", {31'd0, fq_valid}, 32'd0);
    chk("arst_en", {31'd0, IM_en}, 32'd0);
    chk("arst_addr", IM_addr, 32'h0);
    tick();
    tick(); rst = 1'b1; fq_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      smp();
      if (fq_valid) hit = 1'b1;
      else tick();
    end
    if (hit) chk("arst_first_pc", fq_pc, 32'h0);
    else     chk("arst_timeout", 32'd0, 32'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
